ps2_key_encoder: RTL
====================

PS2_KEY_ENCODER -- requirements
Module: ps2_key_encoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive clk_sys cycles a synchronized ps2_clk level must hold before it is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: clk_sys cycles without an accepted ps2_clk falling edge before a partial frame is aborted.
REQ-003 clk_sys  in  1  system clock; single clock domain; one clock, reset asynchronous active-low.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 ps2_clk  in  1  raw PS/2 clock from keyboard, asynchronous to clk_sys.
REQ-006 ps2_data  in  1  raw PS/2 data from keyboard, asynchronous to clk_sys.
REQ-007 ps2_key  out  11  [7:0] scancode, [8] extended (E0-prefixed), [9] pressed, [10] toggles once per reported event.
REQ-008 key_stb  out  1  one-cycle pulse coincident with each ps2_key update.
REQ-009 frame_err  out  1  one-cycle pulse per discarded frame (parity, stop bit or timeout).

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before use.
REQ-011 The filtered clock SHALL change only after the synchronized ps2_clk holds the new level for FILTER_LEN consecutive cycles; shorter glitches SHALL be ignored.
REQ-012 A bit SHALL be sampled from synchronized ps2_data in the cycle a filtered-clock 1->0 transition is detected.
REQ-013 FSM states: IDLE, SHIFT, CHECK.
REQ-014 IDLE: sampled bit 0 -> SHIFT with bit count 1; sampled bit 1 -> stay IDLE, no error.
REQ-015 SHIFT: collects 10 further bits (8 data LSB first, odd parity, stop); after the stop bit -> CHECK.
REQ-016 CHECK: lasts one cycle, then -> IDLE unconditionally.
REQ-017 Frame valid when stop bit = 1 and (per REQ-030) the parity bit makes the count of ones across data+parity odd.
REQ-018 Invalid frame: byte dropped, E0/F0 flags cleared, E1 skip counter cleared, frame_err pulses in the CHECK cycle.
REQ-019 Timeout: in SHIFT, an idle counter reaching TIMEOUT_CYCLES with no accepted edge -> IDLE, frame_err pulse, prefix flags cleared; counter resets on every accepted edge.
REQ-020 Valid byte 0xE0 sets the ext flag; 0xF0 sets the rel flag; neither produces output.
REQ-021 Valid byte 0xE1 loads the skip counter with 7; while the skip counter is nonzero, each valid byte decrements it and produces no output.
REQ-022 Any other valid byte: ps2_key[7:0] = byte, [8] = ext, [9] = ~rel, [10] inverted; key_stb = 1; ext and rel cleared.
REQ-023 Latency: ps2_key and key_stb update on the clk_sys edge ending the CHECK cycle, i.e. 2 cycles after stop-bit edge detection.
REQ-024 Between events ps2_key SHALL hold its value; ps2_key[10] changes exactly once per REQ-022 event.
REQ-025 An edge arriving during CHECK SHALL be treated as a start-bit sample in IDLE on the following cycle only if it is still pending; otherwise it is lost, with no error.

Reset
REQ-026 On reset_n low, asynchronously: ps2_key = 0, key_stb = 0, frame_err = 0, state = IDLE, flags and counters = 0, synchronizer and filter = 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse.
REQ-028 After reset_n rises, the first valid frame SHALL be decoded normally.

Configuration
REQ-029 Macro PS2_KEY_PARITY_EN.
REQ-030 Defined: parity is checked per REQ-017. Undefined: the parity bit is shifted in and ignored, and only the stop bit and timeout cause frame_err.

Verification
REQ-031 Frame 0x1C with good parity -> ps2_key[9:0] = 0x21C, [10] toggles, key_stb pulses once.
REQ-032 Frames E0, F0, 75 -> one event, ps2_key[9:0] = 0x175, no output for the prefixes.
REQ-033 Frame 0x1C with even parity, macro defined -> no toggle, frame_err pulses; macro undefined -> 0x21C reported.
REQ-034 5 bits, then ps2_clk stalled for TIMEOUT_CYCLES, then frame 0x29 -> one frame_err, then ps2_key[9:0] = 0x229.
REQ-035 ps2_clk glitch low for FILTER_LEN-1 cycles in IDLE -> no state change; 8-byte E1 pause sequence -> no event.
REQ-036 reset_n pulsed low after 6 bits of a frame -> all outputs 0, no frame_err; next frame 0x16 -> 0x216.

Source files
------------

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches ps2_clk, frames 11-bit words,
// decodes E0/F0/E1 prefixes into key events. Define PS2_KEY_PARITY_EN to check odd parity.
module ps2_key_encoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_stb,
  output logic        frame_err
);

  localparam int unsigned FW  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BCW = 4;
  localparam int unsigned SKW = 3;

  localparam logic [BCW-1:0] LAST_BIT_CNT = BCW'(10);
  localparam logic [7:0]     BYTE_E0      = 8'hE0;
  localparam logic [7:0]     BYTE_F0      = 8'hF0;
  localparam logic [7:0]     BYTE_E1      = 8'hE1;
  localparam logic [SKW-1:0] PAUSE_SKIP   = SKW'(7);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt, r_filt_d;
  logic [FW-1:0] r_filt_cnt;

  logic [BCW-1:0] r_bit_cnt;
  logic [9:0]     r_shift;
  logic [TW-1:0]  r_idle_cnt;
  logic           r_ext, r_rel;
  logic [SKW-1:0] r_skip;
  logic [10:0]    r_key;
  logic           r_key_stb, r_frame_err;

  logic w_fall, w_stop_edge, w_timeout;
  logic w_par_ok_now, w_par_ok_chk, w_frame_ok_now, w_frame_ok_chk;
  logic [7:0] w_byte;

  // Two-flop synchronizers for both PS/2 lines
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Clock filter: accept a new level only after FILTER_LEN consecutive cycles
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_fall      = r_filt_d & ~r_filt;
  assign w_stop_edge = (r_state == S_SHIFT) && w_fall && (r_bit_cnt == LAST_BIT_CNT);
  assign w_timeout   = (r_state == S_SHIFT) && !w_fall &&
                       (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_byte      = r_shift[7:0];

`ifdef PS2_KEY_PARITY_EN
  assign w_par_ok_now = ^r_shift[9:1];
  assign w_par_ok_chk = ^r_shift[8:0];
`else
  assign w_par_ok_now = 1'b1;
  assign w_par_ok_chk = 1'b1;
`endif

  // Validity is judged both at the stop edge (for frame_err) and in CHECK (for decode)
  assign w_frame_ok_now = r_dat_s2 & w_par_ok_now;
  assign w_frame_ok_chk = r_shift[9] & w_par_ok_chk;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_fall && !r_dat_s2) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_stop_edge)    w_state_nxt = S_CHECK;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame datapath, prefix tracking and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_idle_cnt  <= '0;
      r_ext       <= 1'b0;
      r_rel       <= 1'b0;
      r_skip      <= '0;
      r_key       <= '0;
      r_key_stb   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_stb   <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_idle_cnt <= '0;
          if (w_fall && !r_dat_s2) begin
            r_bit_cnt <= BCW'(1);
            r_shift   <= '0;
          end
        end
        S_SHIFT: begin
          if (w_fall) begin
            r_shift    <= {r_dat_s2, r_shift[9:1]};
            r_bit_cnt  <= r_bit_cnt + BCW'(1);
            r_idle_cnt <= '0;
            if (w_stop_edge && !w_frame_ok_now) r_frame_err <= 1'b1;
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
            r_idle_cnt  <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
          end
        end
        S_CHECK: begin
          if (!w_frame_ok_chk) begin
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
            r_skip <= '0;
          end else if (r_skip != '0) begin
            r_skip <= r_skip - SKW'(1);
          end else if (w_byte == BYTE_E0) begin
            r_ext <= 1'b1;
          end else if (w_byte == BYTE_F0) begin
            r_rel <= 1'b1;
          end else if (w_byte == BYTE_E1) begin
            r_skip <= PAUSE_SKIP;
          end else begin
            r_key     <= {~r_key[10], ~r_rel, r_ext, w_byte};
            r_key_stb <= 1'b1;
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
          end
        end
        default: r_idle_cnt <= '0;
      endcase
    end
  end

  assign ps2_key   = r_key;
  assign key_stb   = r_key_stb;
  assign frame_err = r_frame_err;

endmodule
